io_pwr_seq_ctrl: RTL

Digital controller on the core side of the 1.8 V IO pad-ring supply (VPW/VDDIO). It synchronises and debounces the analog supply-good indicator for the pad-ring supply, then releases pad retention and enables pad outputs in a fixed, timed order. On supply loss it forces the pads into their safe state (retention held, outputs disabled) and latches a fault. It sits in the always-on domain next to the pad ring and feeds pad control and chip status logic.

---
 rtl/io_pwr_seq_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/io_pwr_seq_ctrl.sv
// IO pad-ring (VDDIO) power sequencer: synchronises/debounces supply-good, releases
// pad retention then output enable in a timed order, and forces safe pads on supply loss.
module io_pwr_seq_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned RET_DLY     = 8,
  parameter int unsigned OE_DLY      = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vpw_good_async,
  input  logic       pwr_req,
  input  logic       fault_clr,
  output logic       pad_ret,
  output logic       pad_oe_en,
  output logic       io_ready,
  output logic       fault,
  output logic [2:0] seq_state
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(RET_DLY - 1);
  localparam logic [CNT_W-1:0] OE_LAST  = CNT_W'(OE_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_ENABLE   = 3'd3,
    ST_READY    = 3'd4,
    ST_SHUTDOWN = 3'd5,
    ST_FAULT    = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pad_ret_q, pad_ret_d;
  logic                   pad_oe_en_q, pad_oe_en_d;
  logic                   io_ready_q, io_ready_d;
  logic                   fault_q, fault_d;
  logic                   vpw_good_s;

  assign vpw_good_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      sync_q      <= '0;
      pad_ret_q   <= 1'b1;
      pad_oe_en_q <= 1'b0;
      io_ready_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= sync_d;
      pad_ret_q   <= pad_ret_d;
      pad_oe_en_q <= pad_oe_en_d;
      io_ready_q  <= io_ready_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], vpw_good_async};
    pad_ret_d   = 1'b1;
    pad_oe_en_d = 1'b0;
    io_ready_d  = 1'b0;
    fault_d     = 1'b0;

    // Supply loss outranks a dropped request, which outranks counter expiry.
    case (state_q)
      ST_OFF: begin
        if (vpw_good_s && pwr_req) begin
          state_d = ST_DEBOUNCE;
          cnt_d   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!vpw_good_s || !pwr_req) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (!vpw_good_s) begin
          state_d = ST_FAULT;
          cnt_d   = '0;
        end else if (!pwr_req) begin
          state_d = ST_SHUTDOWN;
          cnt_d   = '0;
        end else if (cnt_q == RET_LAST) begin
          state_d = ST_ENABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_ENABLE: begin
        if (!vpw_good_s) begin
          state_d = ST_FAULT;
          cnt_d   = '0;
        end else if (!pwr_req) begin
          state_d = ST_SHUTDOWN;
          cnt_d   = '0;
        end else if (cnt_q == OE_LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_READY: begin
        if (!vpw_good_s) begin
          state_d = ST_FAULT;
          cnt_d   = '0;
        end else if (!pwr_req) begin
          state_d = ST_SHUTDOWN;
          cnt_d   = '0;
        end
      end
      ST_SHUTDOWN: begin
        if (!vpw_good_s) begin
          state_d = ST_FAULT;
          cnt_d   = '0;
        end else if (cnt_q == OE_LAST) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_FAULT;
        cnt_d   = '0;
      end
    endcase

    // Moore decode; registered so pads follow the state one cycle later.
    case (state_q)
      ST_RELEASE:  pad_ret_d = 1'b0;
      ST_ENABLE: begin
        pad_ret_d   = 1'b0;
        pad_oe_en_d = 1'b1;
      end
      ST_READY: begin
        pad_ret_d   = 1'b0;
        pad_oe_en_d = 1'b1;
        io_ready_d  = 1'b1;
      end
      ST_SHUTDOWN: pad_ret_d = 1'b0;
      ST_FAULT:    fault_d   = 1'b1;
      default: ;
    endcase
  end

  assign pad_ret   = pad_ret_q;
  assign pad_oe_en = pad_oe_en_q;
  assign io_ready  = io_ready_q;
  assign fault     = fault_q;
  assign seq_state = state_q;

endmodule
